ristretto_fetch_stage: RTL
==========================

Name: ristretto_fetch_stage

Overview:
Instruction fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the fetch PC, issues word requests on the instruction memory port (req/gnt request phase, in-order rvalid response phase), buffers returned words with their PCs in a small prefetch FIFO, and presents them to decode with a valid/stall handshake. Redirects from execute (taken branch, JAL/JALR, trap, MRET) flush the buffer and discard responses still in flight.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, prefetch entries (power of two, >= 2); also the maximum number of outstanding requests

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
imem_req_o  out  1  request valid
imem_addr_o  out  32  word address; bits [1:0] always 0
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (in order, at least 1 cycle after its gnt)
imem_rdata_i  in  32  response instruction word
imem_err_i  in  1  bus error, qualified by imem_rvalid_i
redirect_i  in  1  flush and refetch from redirect_pc_i
redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored
dec_stall_i  in  1  decode cannot accept an instruction this cycle
dec_valid_o  out  1  dec_instr_o, dec_pc_o and dec_err_o are valid
dec_instr_o  out  32  instruction word
dec_pc_o  out  32  PC of dec_instr_o
dec_err_o  out  1  fetch bus error for this entry

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is synchronous and active-low. All state updates on posedge clk_i.
- Reset values:
  - imem_req_o = 0, dec_valid_o = 0.
  - fetch_pc = BOOT_ADDR, FIFO empty, outstanding = 0, discard = 0, FSM = BOOT.
  - dec_instr_o = 32'h0000_0013 (NOP), dec_pc_o = 0, dec_err_o = 0 when the FIFO is empty.
- FSM states and transitions:
  - BOOT: lasts 1 cycle, then RUN.
  - RUN: imem_req_o = 1 when fifo_count + outstanding < FIFO_DEPTH.
    - imem_addr_o = {fetch_pc[31:2], 2'b00}.
    - On req & gnt: fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
  - HOLD: entered when redirect_i arrives while imem_req_o = 1 and gnt = 0.
    - req and addr stay stable until gnt, because a request is never withdrawn or altered before gnt.
    - On gnt, that request is counted as a discard, and the FSM moves to RUN fetching from the latched redirect PC.
    - A further redirect_i in HOLD overwrites the latched PC.
- Response handling:
  - On rvalid, outstanding decrements.
  - If discard > 0: discard decrements and the data is dropped.
  - Otherwise {rdata, pc, err} is pushed into the FIFO. The entry PC comes from a PC queue in request order.
- Redirect (highest priority):
  - Same cycle: dec_valid_o is masked to 0 and no pop occurs.
  - Next cycle: FIFO empty.
  - discard = outstanding after this cycle's gnt/rvalid updates, excluding a response consumed this cycle.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}, unless the FSM enters HOLD.
  - No request is granted in the redirect cycle with the old PC unless it was already pending (HOLD case).
- Decode handshake:
  - dec_valid_o = !fifo_empty & !redirect_i.
  - Pop when dec_valid_o & !dec_stall_i.
  - Outputs are held stable while stalled.
- Latency:
  - Redirect in cycle N: req with the target in N+1 (zero-wait-state gnt), rvalid earliest N+2, dec_valid_o at N+3.
  - There is no FIFO bypass.
  - Steady state with a 1-cycle memory: one instruction per cycle.
- Boundaries:
  - Push and pop in the same cycle on a full FIFO are legal; the count is unchanged.
  - Push and redirect in the same cycle: the push is dropped.
  - rvalid with outstanding = 0 is a protocol violation; flag it with an assertion and ignore it.
  - Reset mid-transaction: all state is cleared. Responses arriving after reset are the memory model's responsibility; the bench does not deliver them.

Decomposition:
- Package ristretto_fetch_stage_pkg:
  - fetch_entry_t packed struct {instr[31:0], pc[31:0], err}.
  - fetch FSM enum {FETCH_BOOT, FETCH_RUN, FETCH_HOLD}.
  - Parameter NOP_INSTR = 32'h0000_0013.
- Sub-module ristretto_fetch_fifo:
  - Parameterised on depth and fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count, head.
  - Instantiated once for data entries. The PC queue is a second instance, or merged by writing the PC at gnt time.

Test Plan:
- Reset release, BOOT_ADDR=0, zero-wait memory returning addr-indexed words -> first req in the cycle after BOOT with addr 0x0; dec_valid_o rises 2 cycles after the first gnt; PCs 0x0,0x4,0x8 presented on consecutive cycles.
- Hold dec_stall_i for 5 cycles with FIFO_DEPTH=2 -> at most 2 outstanding + buffered; imem_req_o low while full; dec_pc_o stable; no word lost or duplicated after release.
- redirect_i to 0x100 with 2 responses in flight -> both in-flight responses dropped; next presented pc = 0x100 with its word; dec_valid_o = 0 in the redirect cycle.
- redirect_i to 0x200 while req pending with gnt withheld 3 cycles -> addr held at old value until gnt; that response discarded; next req addr 0x200.
- Memory returns imem_err_i=1 for 0x8 -> entry 0x8 presented with dec_err_o=1; neighbours err=0.
- redirect_pc_i = 0xFFFF_FFFC, then fetch of 2 words -> PCs 0xFFFF_FFFC then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/ristretto_fetch_stage_pkg.sv
// Shared types and constants for the ristretto instruction fetch stage.
//   fetch_entry_t : one buffered fetch result {instr, pc, err}
//   fetch_state_e : request-side FSM states
//   NOP_INSTR     : word presented to decode while nothing is buffered
//   word_align()  : clears the byte-offset bits of an address
package ristretto_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ristretto_fetch_fifo.sv
// Small synchronous FIFO used for the prefetch buffer and the in-flight PC queue.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset (pointers/count only)
//   push_i, data_i : write an entry (accepted when not full, or full with pop)
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : empty the FIFO; wins over push/pop in the same cycle
//   full_o, empty_o, count_o : occupancy
//   head_o         : oldest entry, valid when !empty_o
module ristretto_fetch_fifo
  import ristretto_fetch_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output T                         head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  T              r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == (PW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // Full + push is accepted only when the head leaves in the same cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ristretto_fetch_stage.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word requests on
// the imem req/gnt + in-order rvalid port, buffers responses in a prefetch
// FIFO and hands them to decode with a valid/stall handshake. A redirect
// flushes the buffer and drops every response still in flight.
// Ports:
//   clk_i, rst_n_i                 : clock, synchronous active-low reset
//   imem_req_o/addr_o/gnt_i        : request phase (word aligned address)
//   imem_rvalid_i/rdata_i/err_i    : response phase, in request order
//   redirect_i, redirect_pc_i      : flush and refetch from a new PC
//   dec_stall_i                    : decode cannot accept this cycle
//   dec_valid_o/instr_o/pc_o/err_o : instruction handed to decode
module ristretto_fetch_stage
  import ristretto_fetch_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        dec_stall_i,
  output logic        dec_valid_o,
  output logic [31:0] dec_instr_o,
  output logic [31:0] dec_pc_o,
  output logic        dec_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_hold_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_pending;

  logic          w_gnt_acc;
  logic          w_rsp_acc;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_redirect_pc;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  logic          w_pcq_full;
  logic          w_pcq_empty;
  logic [CW-1:0] w_pcq_count;
  logic [31:0]   w_pcq_head;

  assign w_redirect_pc = word_align(redirect_pc_i);

  // Decode handshake; a redirect hides the stale head in its own cycle.
  assign dec_valid_o = ~w_fifo_empty & ~redirect_i;
  assign w_pop       = dec_valid_o & ~dec_stall_i;
  assign dec_instr_o = w_fifo_empty ? NOP_INSTR : w_head.instr;
  assign dec_pc_o    = w_fifo_empty ? 32'h0     : w_head.pc;
  assign dec_err_o   = w_fifo_empty ? 1'b0      : w_head.err;

  // Buffered plus in-flight words must fit the FIFO; the slot freed by this
  // cycle's pop is credited so a 1-cycle memory sustains one word per cycle.
  assign w_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);
  assign w_room = (w_used < (CW+1)'(FIFO_DEPTH));

  // A request left ungranted stays up (r_pending); a fresh one is not raised
  // in a redirect cycle, so only an already-pending request can carry the
  // old PC past a redirect.
  always_comb begin
    imem_req_o = 1'b0;
    unique case (r_state)
      FETCH_RUN:  imem_req_o = r_pending | (w_room & ~redirect_i);
      FETCH_HOLD: imem_req_o = 1'b1;
      default:    imem_req_o = 1'b0;
    endcase
  end
  assign imem_addr_o = r_fetch_pc;

  assign w_gnt_acc = imem_req_o & imem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_acc = imem_rvalid_i & (r_outstanding != '0);
  assign w_drop    = w_rsp_acc & (r_discard != '0);
  assign w_push    = w_rsp_acc & ~w_drop & ~redirect_i;
  assign w_out_nxt = r_outstanding + CW'(w_gnt_acc) - CW'(w_rsp_acc);

  assign w_push_entry = '{instr: imem_rdata_i, pc: w_pcq_head, err: imem_err_i};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state       <= FETCH_BOOT;
      r_fetch_pc    <= word_align(BOOT_ADDR);
      r_outstanding <= '0;
      r_discard     <= '0;
      r_pending     <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_pending     <= imem_req_o & ~imem_gnt_i;

      // Everything still in flight after a redirect is stale. In HOLD the
      // held request is stale too, so its grant adds one more to drop.
      if (redirect_i)
        r_discard <= w_out_nxt;
      else if (r_state == FETCH_HOLD && w_gnt_acc)
        r_discard <= r_discard + CW'(1) - CW'(w_drop);
      else
        r_discard <= r_discard - CW'(w_drop);

      unique case (r_state)
        FETCH_BOOT: begin
          r_state <= FETCH_RUN;
          if (redirect_i) r_fetch_pc <= w_redirect_pc;
        end
        FETCH_RUN: begin
          if (redirect_i && imem_req_o && !imem_gnt_i)
            r_state <= FETCH_HOLD;
          else if (redirect_i)
            r_fetch_pc <= w_redirect_pc;
          else if (w_gnt_acc)
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        FETCH_HOLD: begin
          if (imem_gnt_i) begin
            r_state    <= FETCH_RUN;
            r_fetch_pc <= redirect_i ? w_redirect_pc : r_hold_pc;
          end
        end
        default: r_state <= FETCH_BOOT;
      endcase
    end
  end

  // Latched redirect target while the old request waits for its grant.
  always_ff @(posedge clk_i) begin
    if ((r_state == FETCH_RUN && redirect_i && imem_req_o && !imem_gnt_i) ||
        (r_state == FETCH_HOLD && redirect_i && !imem_gnt_i))
      r_hold_pc <= w_redirect_pc;
  end

  ristretto_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count),
    .head_o  (w_head)
  );

  // PCs in request order; popped by every response, including dropped ones,
  // so it is never flushed.
  ristretto_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [31:0])
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_gnt_acc),
    .data_i  (r_fetch_pc),
    .pop_i   (w_rsp_acc),
    .flush_i (1'b0),
    .full_o  (w_pcq_full),
    .empty_o (w_pcq_empty),
    .count_o (w_pcq_count),
    .head_o  (w_pcq_head)
  );

`ifndef SYNTHESIS
  a_rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_rvalid_i |-> (r_outstanding != '0));
  a_pcq_tracks_outstanding: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (w_pcq_count == r_outstanding));
  a_pcq_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_gnt_acc && w_pcq_full));
  a_pcq_has_pc: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    w_rsp_acc |-> !w_pcq_empty);
  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(w_push && w_fifo_full && !w_pop));
`endif

endmodule
